// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a data port onto a single
//   AXI4-Lite master. Only one transaction is in flight at a time.
//
//   Ports:
//     clk, rst             single clock, synchronous active-high reset
//     if_*                 fetch requester (always reads)
//     dm_*                 data requester (read or write, dm_we=1 writes)
//     aw*/w*/b*/ar*/r*     AXI4-Lite master channels
//
//   Configuration macro:
//     MEM_ARBITER_ROUND_ROBIN_EN  when defined, simultaneous requests
//                                 alternate between the two requesters;
//                                 otherwise the data port always wins.
//
//   With a zero-wait-state slave, ack rises 3 cycles after the edge
//   that samples the request, for both reads and writes.

module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_ack,
    output logic                    if_err,

    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_ack,
    output logic                    dm_err,

    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_dm_q, gnt_dm_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    if_ack_q, if_ack_d;
    logic                    dm_ack_q, dm_ack_d;
    logic                    if_err_q, if_err_d;
    logic                    dm_err_q, dm_err_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic                    pick_dm;
    logic                    aw_pending, w_pending;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // 1 when the data port received the most recent grant.
    logic                    last_dm_q, last_dm_d;
`endif

    // Arbitration decision: who would win if IDLE sampled requests now.
    always_comb begin
        pick_dm = dm_req;
        if (dm_req && if_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            pick_dm = !last_dm_q;
`else
            pick_dm = 1'b1;
`endif
        end
    end

    // A write channel stays pending until its own handshake; the two
    // channels complete independently.
    assign aw_pending = awvalid_q && !awready;
    assign w_pending  = wvalid_q && !wready;

    always_comb begin
        state_d     = state_q;
        gnt_dm_d    = gnt_dm_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_err_d    = if_err_q;
        dm_err_d    = dm_err_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_dm_d   = last_dm_q;
`endif

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    gnt_dm_d = pick_dm;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    last_dm_d = pick_dm;
`endif
                    if (pick_dm) begin
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        wstrb_d = dm_wstrb;
                    end else begin
                        // Fetches are reads regardless of dm_we.
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end
                    if (pick_dm && dm_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rready_d    = 1'b0;
                    resp_data_d = rdata;
                    resp_err_d  = (rresp != 2'b00);
                    state_d     = DONE;
                end
            end
            WR_ADDR: begin
                awvalid_d = aw_pending;
                wvalid_d  = w_pending;
                if (!aw_pending && !w_pending) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d   = 1'b0;
                    resp_err_d = (bresp != 2'b00);
                    state_d    = DONE;
                end
            end
            DONE: begin
                // Ack, data and error are registered together so they are
                // all valid in the same cycle; the other port is untouched.
                if (gnt_dm_q) begin
                    dm_ack_d = 1'b1;
                    dm_err_d = resp_err_q;
                    if (!we_q) begin
                        dm_rdata_d = resp_data_q;
                    end
                end else begin
                    if_ack_d   = 1'b1;
                    if_err_d   = resp_err_q;
                    if_rdata_d = resp_data_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_dm_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_dm_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_dm_q    <= gnt_dm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_dm_q   <= last_dm_d;
`endif
        end
    end

    assign awaddr   = addr_q;
    assign araddr   = addr_q;
    assign wdata    = wdata_q;
    assign wstrb    = wstrb_q;
    assign awvalid  = awvalid_q;
    assign wvalid   = wvalid_q;
    assign bready   = bready_q;
    assign arvalid  = arvalid_q;
    assign rready   = rready_q;
    assign if_ack   = if_ack_q;
    assign dm_ack   = dm_ack_q;
    assign if_err   = if_err_q;
    assign dm_err   = dm_err_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width of all ports; wstrb width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have fetch port: if_req in 1 (read request); if_addr in ADDR_WIDTH; if_rdata out DATA_WIDTH; if_ack out 1 (completion); if_err out 1 (rresp!=0).
REQ-006 SHALL have data port: dm_req in 1; dm_we in 1 (1=write); dm_addr in ADDR_WIDTH; dm_wdata in DATA_WIDTH; dm_wstrb in DATA_WIDTH/8; dm_rdata out DATA_WIDTH; dm_ack out 1; dm_err out 1 (rresp/bresp!=0).
REQ-007 SHALL have AXI4-Lite master port: awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp[1:0]/bvalid in, bready out; araddr/arvalid out, arready in; rdata/rresp[1:0]/rvalid in, rready out.

Function
REQ-008 SHALL be one transaction in flight; FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
REQ-009 IDLE: on a clock edge with a request pending, grant one requester, register its addr/wdata/wstrb/we, go to RD_ADDR (read) or WR_ADDR (write).
REQ-010 RD_ADDR: arvalid=1 with registered address; on arvalid&&arready go to RD_DATA.
REQ-011 RD_DATA: rready=1; on rvalid, register rdata and rresp, go to DONE.
REQ-012 WR_ADDR: awvalid and wvalid both raised on entry, each dropped independently after its own handshake; go to WR_RESP once both are done, including same-cycle completion.
REQ-013 WR_RESP: bready=1; on bvalid, register bresp, go to DONE.
REQ-014 DONE: pulse the granted requester's ack for exactly one cycle, with rdata and err valid that cycle; return to IDLE.
REQ-015 Requesters SHALL hold req and request fields stable until ack; req still high in the cycle after ack is a new request.
REQ-016 Zero-wait-state slave: ack SHALL assert 3 cycles after the req-sampling edge for reads, and 3 cycles after it for writes.
REQ-017 Fetch requests are always reads; the block SHALL ignore dm_we for the fetch port.
REQ-018 AXI valids SHALL stay asserted until their handshake, with addr/data stable meanwhile.
REQ-019 The non-granted requester's ack SHALL stay 0; its rdata/err outputs SHALL hold their last values.

Reset
REQ-020 While rst=1 at an edge: FSM to IDLE; all valid/ready outputs 0; if_ack, dm_ack, if_err, dm_err 0; if_rdata, dm_rdata 0; arbitration pointer to "fetch last granted".
REQ-021 Reset mid-transaction SHALL abandon the transaction with no ack; the next edge after rst deasserts may grant.

Configuration
REQ-022 Macro MEM_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL grant the requester not granted last, updating the pointer on every grant.
REQ-023 Without MEM_ARBITER_ROUND_ROBIN_EN, the data port SHALL always win simultaneous requests, with no pointer register.

Verification
REQ-024 Fetch read 0x100 with arready=1 and rvalid=1 immediately, rdata=0xDEADBEEF -> if_ack=1 for one cycle, 3 cycles after the sampling edge, with if_rdata=0xDEADBEEF and if_err=0.
REQ-025 Data write 0x200, wdata=0x12345678, wstrb=0xF; wready delayed 2 cycles after awready -> awvalid drops first, wvalid holds until wready; one dm_ack.
REQ-026 if_req and dm_req rise in the same cycle, repeated 4 times -> RR build grants D,F,D,F; non-RR build grants D for all 4 (fetch starves while dm_req is held).
REQ-027 rst pulsed while in RD_DATA with rvalid=0 -> arvalid=rready=0 next cycle, no ack, then a fresh grant after reset.
REQ-028 Read with rresp=2'b10 -> dm_ack with dm_err=1; the next OKAY transaction clears dm_err=0.
